ram_arbiter: RTL

Two-requester access controller for the 32 x 32-bit single-port data `ram`. It sits between the core's load/store unit (port 0) and the debug/loader port (port 1), and serialises both onto the ram's single `i_addr`/`i_data`/`i_we`/`o_data` interface. It grants one access at a time through a two-state FSM and returns read data with a completion pulse. A read and a write can never collide at the ram.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/arb_pick2.sv | 27 ++
 rtl/ram_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-ram access path: width defaults,
// arbiter FSM state codes and port ids.
package mips_mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;
  localparam logic ARB_P0   = 1'b0;
  localparam logic ARB_P1   = 1'b1;

  typedef enum logic {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY
  } arb_state_e;
endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way winner select. RAM_ARB_ROUND_ROBIN_EN selects
// alternating tie-break on the last winner; otherwise port 0 wins ties.
module arb_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_vld,
  output logic       o_win
);
  import mips_mem_pkg::*;

  assign o_vld = |i_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    o_win = ARB_P0;
    if (i_req == 2'b11) o_win = ~i_last;
    else if (i_req[1])  o_win = ARB_P1;
  end
`else
  logic unused_last;
  assign unused_last = i_last;

  always_comb begin
    o_win = i_req[0] ? ARB_P0 : ARB_P1;
  end
`endif
endmodule

// File: rtl/ram_arbiter.sv
// Two-port access controller serialising port 0 / port 1 onto the single-port
// data ram. Build option: RAM_ARB_ROUND_ROBIN_EN (round-robin tie-break).
module ram_arbiter #(
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_p0_req,
  input  logic              i_p0_we,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  output logic              o_p0_gnt,
  output logic              o_p0_ack,
  output logic [DATA_W-1:0] o_p0_rdata,
  input  logic              i_p1_req,
  input  logic              i_p1_we,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  output logic              o_p1_gnt,
  output logic              o_p1_ack,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_data
);
  import mips_mem_pkg::*;

  arb_state_e               state_q, state_d;
  logic                     win_q, win_d;
  logic                     ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_data_q, ram_data_d;
  logic [1:0]               gnt_q, gnt_d;
  logic [1:0]               ack_q, ack_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
  logic                     last_w, pick_vld, pick_id;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign last_w = last_q;
`else
  assign last_w = ARB_P1;
`endif

  arb_pick2 u_pick (
    .i_req  ({i_p1_req, i_p0_req}),
    .i_last (last_w),
    .o_vld  (pick_vld),
    .o_win  (pick_id)
  );

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    gnt_d      = '0;
    ack_d      = '0;
    rdata_d    = rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ram_we_d = 1'b0;
        if (pick_vld) begin
          state_d        = ST_BUSY;
          win_d          = pick_id;
          gnt_d[pick_id] = 1'b1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d         = pick_id;
`endif
          if (pick_id == ARB_P1) begin
            ram_we_d   = i_p1_we;
            ram_addr_d = i_p1_addr;
            ram_data_d = i_p1_wdata;
          end else begin
            ram_we_d   = i_p0_we;
            ram_addr_d = i_p0_addr;
            ram_data_d = i_p0_wdata;
          end
        end
      end
      default: begin
        // The ram has seen the command for one cycle; its write lands on this edge.
        if (!ram_we_q) rdata_d[win_q] = i_ram_data;
        ack_d[win_q] = 1'b1;
        ram_we_d     = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= ARB_P0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q     <= ARB_P1;
`endif
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign o_p0_gnt   = gnt_q[0];
  assign o_p1_gnt   = gnt_q[1];
  assign o_p0_ack   = ack_q[0];
  assign o_p1_ack   = ack_q[1];
  assign o_p0_rdata = rdata_q[0];
  assign o_p1_rdata = rdata_q[1];
  assign o_ram_we   = ram_we_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_data = ram_data_q;
endmodule
